pc_redirect_ctrl: RTL and testbench

- Sequences the program counter: merges redirect requests from decode (jump) and execute (jr, jalr, taken branch) with the load-use stall and instruction-fetch readiness.
- Produces one-hot PC selects, a single redirect target, a PC hold, and pipeline flush strobes.
- Buffers a redirect that cannot be applied while fetch is not ready.
- Sits between the ID/EX stages, the hazard unit and the PC register.

---
 rtl/pc_redirect_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// PC sequencing: merges decode/execute redirects with the stall and fetch readiness.
// A redirect that fetch cannot take yet is parked in PEND until fetch_ready rises.
//
// state | meaning
// RUN   | normal flow; new redirect requests are resolved every cycle
// PEND  | a redirect is latched, waiting for fetch_ready; new requests are wrong-path
module pc_redirect_ctrl #(
  parameter int AW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             id_j,
  input  logic [AW-1:0]    id_target,
  input  logic             ex_jr,
  input  logic             ex_jalr,
  input  logic             ex_bra,
  input  logic [AW-1:0]    ex_jr_target,
  input  logic [AW-1:0]    ex_jalr_target,
  input  logic [AW-1:0]    ex_bra_target,
  output logic             j,
  output logic             jr,
  output logic             bra,
  output logic             jalr,
  output logic [AW-1:0]    redirect_addr,
  output logic             pc_hold,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             conflict_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam logic [1:0] K_J    = 2'd0;
  localparam logic [1:0] K_JR   = 2'd1;
  localparam logic [1:0] K_BRA  = 2'd2;
  localparam logic [1:0] K_JALR = 2'd3;

  state_t          state, state_nxt;
  logic [1:0]      pend_kind;
  logic [AW-1:0]   pend_tgt;
  logic            ex_any, ex_multi, req;
  logic [1:0]      req_kind;
  logic [AW-1:0]   req_tgt;
  logic            sel_en;
  logic [1:0]      sel_kind;

  // EX holds the older instruction, so it outranks the ID jump; a stalled jump is not a request.
  always_comb begin
    ex_any   = ex_jr | ex_jalr | ex_bra;
    ex_multi = (ex_jr & ex_jalr) | (ex_jr & ex_bra) | (ex_jalr & ex_bra);
    req      = ex_any | (id_j & ~stall);
    req_kind = K_J;
    req_tgt  = id_target;
    if (ex_jr) begin
      req_kind = K_JR;
      req_tgt  = ex_jr_target;
    end else if (ex_jalr) begin
      req_kind = K_JALR;
      req_tgt  = ex_jalr_target;
    end else if (ex_bra) begin
      req_kind = K_BRA;
      req_tgt  = ex_bra_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (req && !fetch_ready) state_nxt = PEND;
      PEND:    if (fetch_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    sel_en        = 1'b0;
    sel_kind      = K_J;
    redirect_addr = '0;
    pc_hold       = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (req) begin
            flush_ifid = 1'b1;
            flush_idex = ex_any;
            if (fetch_ready) begin
              sel_en        = 1'b1;
              sel_kind      = req_kind;
              redirect_addr = req_tgt;
            end else begin
              pc_hold = 1'b1;
            end
          end else begin
            pc_hold = stall | ~fetch_ready;
          end
        end
        PEND: begin
          if (fetch_ready) begin
            sel_en        = 1'b1;
            sel_kind      = pend_kind;
            redirect_addr = pend_tgt;
          end else begin
            pc_hold = 1'b1;
          end
        end
        default: ;
      endcase
    end
    j    = sel_en && (sel_kind == K_J);
    jr   = sel_en && (sel_kind == K_JR);
    bra  = sel_en && (sel_kind == K_BRA);
    jalr = sel_en && (sel_kind == K_JALR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_kind <= K_J;
      pend_tgt  <= '0;
    end else if (state == RUN && req && !fetch_ready) begin
      pend_kind <= req_kind;
      pend_tgt  <= req_tgt;
    end
  end

  // Wrong-path EX signals seen in PEND must not raise the conflict flag.
  always_ff @(posedge clk) begin
    if (rst)                         conflict_err <= 1'b0;
    else if (state == RUN && ex_multi) conflict_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      redirect_cnt <= '0;
    else if (sel_en && redirect_cnt != {CNT_W{1'b1}})
      redirect_cnt <= redirect_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model; a second instance with a 4-bit counter checks saturation.
module tb_pc_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst, fetch_ready, stall, id_j, ex_jr, ex_jalr, ex_bra;
  logic [7:0] id_target, ex_jr_target, ex_jalr_target, ex_bra_target;
  logic       j, jr, bra, jalr, pc_hold, flush_ifid, flush_idex, conflict_err;
  logic [7:0] redirect_addr;
  logic [15:0] redirect_cnt;
  logic       s_j, s_jr, s_bra, s_jalr, s_pc_hold, s_flush_ifid, s_flush_idex, s_conflict_err;
  logic [7:0] s_redirect_addr;
  logic [3:0] s_redirect_cnt;
  logic [14:0] obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.AW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .id_j(id_j), .id_target(id_target),
    .ex_jr(ex_jr), .ex_jalr(ex_jalr), .ex_bra(ex_bra),
    .ex_jr_target(ex_jr_target), .ex_jalr_target(ex_jalr_target), .ex_bra_target(ex_bra_target),
    .j(j), .jr(jr), .bra(bra), .jalr(jalr), .redirect_addr(redirect_addr),
    .pc_hold(pc_hold), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .conflict_err(conflict_err), .redirect_cnt(redirect_cnt)
  );

  pc_redirect_ctrl #(.AW(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .id_j(id_j), .id_target(id_target),
    .ex_jr(ex_jr), .ex_jalr(ex_jalr), .ex_bra(ex_bra),
    .ex_jr_target(ex_jr_target), .ex_jalr_target(ex_jalr_target), .ex_bra_target(ex_bra_target),
    .j(s_j), .jr(s_jr), .bra(s_bra), .jalr(s_jalr), .redirect_addr(s_redirect_addr),
    .pc_hold(s_pc_hold), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
    .conflict_err(s_conflict_err), .redirect_cnt(s_redirect_cnt)
  );

  // Observed bundle: {j,jr,bra,jalr, addr, hold, flush_ifid, flush_idex}
  assign obs = {j, jr, bra, jalr, redirect_addr, pc_hold, flush_ifid, flush_idex};

  // Reference model: one-hot select codes in bundle order
  localparam logic [3:0] S_J = 4'b1000, S_JR = 4'b0100, S_BRA = 4'b0010, S_JALR = 4'b0001;
  typedef struct {logic [3:0] sel; logic [7:0] tgt;} redir_t;
  redir_t      pendq[$];
  redir_t      m_r;
  bit          m_req, m_conf;
  int          m_ex_n, m_cnt;
  logic [14:0] e_bundle;

  task automatic model_eval();
    logic [3:0] sel = 4'b0;
    logic [7:0] addr = 8'h00;
    logic hold = 1'b0, fi = 1'b0, fe = 1'b0;
    m_req  = 1'b0;
    m_ex_n = int'(ex_jr) + int'(ex_jalr) + int'(ex_bra);
    if (rst) begin
    end else if (pendq.size() != 0) begin
      if (fetch_ready) begin sel = pendq[0].sel; addr = pendq[0].tgt; end
      else hold = 1'b1;
    end else begin
      if (ex_jr)                begin m_req = 1; m_r.sel = S_JR;   m_r.tgt = ex_jr_target;   end
      else if (ex_jalr)         begin m_req = 1; m_r.sel = S_JALR; m_r.tgt = ex_jalr_target; end
      else if (ex_bra)          begin m_req = 1; m_r.sel = S_BRA;  m_r.tgt = ex_bra_target;  end
      else if (id_j && !stall)  begin m_req = 1; m_r.sel = S_J;    m_r.tgt = id_target;      end
      if (m_req) begin
        fi = 1'b1;
        fe = (m_ex_n > 0);
        if (fetch_ready) begin sel = m_r.sel; addr = m_r.tgt; end
        else hold = 1'b1;
      end else begin
        hold = stall || !fetch_ready;
      end
    end
    e_bundle = {sel, addr, hold, fi, fe};
  endtask

  task automatic model_commit();
    if (rst) begin
      pendq.delete();
      m_conf = 0;
      m_cnt  = 0;
    end else begin
      if (e_bundle[14:11] != 4'b0) m_cnt++;
      if (pendq.size() != 0) begin
        if (fetch_ready) void'(pendq.pop_front());
      end else begin
        if (m_req && !fetch_ready) pendq.push_back(m_r);
        if (m_ex_n > 1) m_conf = 1;
      end
    end
  endtask

  task automatic clear_inputs();
    stall = 0; id_j = 0; ex_jr = 0; ex_jalr = 0; ex_bra = 0;
    id_target = 8'h00; ex_jr_target = 8'h00; ex_jalr_target = 8'h00; ex_bra_target = 8'h00;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; fetch_ready = 1; clear_inputs();
    ex_jr = 1; ex_jr_target = 8'hAA; id_j = 1;
    settle();
    n_vec++;
    if (obs !== 15'h0) begin n_err++; $display("FAIL reset_outputs got %h want %h", obs, 15'h0); end
    advance();
    advance();
    rst = 0; clear_inputs();
    n_vec++;
    if (conflict_err !== 1'b0 || redirect_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_regs got conf=%b cnt=%0d want conf=0 cnt=0", conflict_err, redirect_cnt);
    end
  endtask

  task automatic test_idle();
    fetch_ready = 1; clear_inputs();
    for (int i = 0; i < 10; i++) begin
      settle();
      n_vec++;
      if (obs !== 15'h0) begin n_err++; $display("FAIL idle_cycle%0d got %h want %h", i, obs, 15'h0); end
      advance();
    end
    n_vec++;
    if (redirect_cnt !== 16'd0) begin n_err++; $display("FAIL idle_cnt got %0d want 0", redirect_cnt); end
  endtask

  task automatic test_bra();
    fetch_ready = 1; clear_inputs();
    ex_bra = 1; ex_bra_target = 8'h3C;
    settle();
    n_vec++;
    if (obs !== {S_BRA, 8'h3C, 3'b011}) begin
      n_err++; $display("FAIL bra_select got %h want %h", obs, {S_BRA, 8'h3C, 3'b011});
    end
    advance();
    clear_inputs();
    settle();
    n_vec++;
    if (obs !== 15'h0 || redirect_cnt !== 16'd1) begin
      n_err++; $display("FAIL bra_after got %h cnt=%0d want 0000 cnt=1", obs, redirect_cnt);
    end
    advance();
  endtask

  task automatic test_jalr_vs_j();
    fetch_ready = 1; clear_inputs();
    id_j = 1; id_target = 8'h10; ex_jalr = 1; ex_jalr_target = 8'h80;
    settle();
    n_vec++;
    if (obs !== {S_JALR, 8'h80, 3'b011}) begin
      n_err++; $display("FAIL jalr_over_j got %h want %h", obs, {S_JALR, 8'h80, 3'b011});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_pend();
    clear_inputs();
    fetch_ready = 0; ex_jr = 1; ex_jr_target = 8'h55;
    settle();
    n_vec++;
    if (obs !== {4'b0, 8'h00, 3'b111}) begin
      n_err++; $display("FAIL pend_request got %h want %h", obs, {4'b0, 8'h00, 3'b111});
    end
    advance();
    ex_jr = 0; id_j = 1; id_target = 8'h77;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_vec++;
      if (obs !== {4'b0, 8'h00, 3'b100}) begin
        n_err++; $display("FAIL pend_wait%0d got %h want %h", i, obs, {4'b0, 8'h00, 3'b100});
      end
      advance();
    end
    fetch_ready = 1;
    settle();
    n_vec++;
    if (obs !== {S_JR, 8'h55, 3'b000}) begin
      n_err++; $display("FAIL pend_release got %h want %h", obs, {S_JR, 8'h55, 3'b000});
    end
    advance();
    id_j = 0;
    settle();
    n_vec++;
    if (obs !== 15'h0) begin n_err++; $display("FAIL pend_after got %h want 0000", obs); end
    advance();
  endtask

  task automatic test_stall();
    fetch_ready = 1; clear_inputs();
    stall = 1; id_j = 1; id_target = 8'h44;
    settle();
    n_vec++;
    if (obs !== {4'b0, 8'h00, 3'b100}) begin
      n_err++; $display("FAIL stall_j got %h want %h", obs, {4'b0, 8'h00, 3'b100});
    end
    advance();
    id_j = 0; ex_jr = 1; ex_jr_target = 8'h20;
    settle();
    n_vec++;
    if (obs !== {S_JR, 8'h20, 3'b011}) begin
      n_err++; $display("FAIL stall_ex got %h want %h", obs, {S_JR, 8'h20, 3'b011});
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_conflict_reset();
    fetch_ready = 1; clear_inputs();
    ex_jr = 1; ex_jr_target = 8'h11; ex_bra = 1; ex_bra_target = 8'h22;
    settle();
    n_vec++;
    if (obs !== {S_JR, 8'h11, 3'b011}) begin
      n_err++; $display("FAIL conflict_sel got %h want %h", obs, {S_JR, 8'h11, 3'b011});
    end
    advance();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    n_vec++;
    if (conflict_err !== 1'b1) begin n_err++; $display("FAIL conflict_sticky got %b want 1", conflict_err); end
    fetch_ready = 0; ex_bra = 1; ex_bra_target = 8'h66;
    settle(); advance();
    ex_bra = 0; rst = 1;
    settle();
    n_vec++;
    if (obs !== 15'h0) begin n_err++; $display("FAIL rst_in_pend got %h want 0000", obs); end
    advance();
    rst = 0; fetch_ready = 1;
    settle();
    n_vec++;
    if (obs !== 15'h0 || conflict_err !== 1'b0 || redirect_cnt !== 16'd0) begin
      n_err++; $display("FAIL rst_release got %h conf=%b cnt=%0d want 0000 conf=0 cnt=0", obs, conflict_err, redirect_cnt);
    end
    advance();
  endtask

  task automatic test_saturation();
    clear_inputs(); fetch_ready = 1; rst = 1;
    settle(); advance();
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      ex_bra = 1; ex_bra_target = 8'($urandom);
      settle(); advance();
    end
    clear_inputs();
    n_vec++;
    if (s_redirect_cnt !== 4'hF || redirect_cnt !== 16'd17) begin
      n_err++; $display("FAIL saturation got sat=%h wide=%0d want sat=f wide=17", s_redirect_cnt, redirect_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] e_cnt;
    logic [3:0]  e_sat;
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 39) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      id_j           = ($urandom_range(0, 2) == 0);
      ex_jr          = ($urandom_range(0, 5) == 0);
      ex_jalr        = ($urandom_range(0, 5) == 0);
      ex_bra         = ($urandom_range(0, 4) == 0);
      id_target      = 8'($urandom);
      ex_jr_target   = 8'($urandom);
      ex_jalr_target = 8'($urandom);
      ex_bra_target  = 8'($urandom);
      settle();
      n_vec++;
      if (obs !== e_bundle) begin n_err++; $display("FAIL rand%0d_comb got %h want %h", i, obs, e_bundle); end
      advance();
      e_cnt = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      e_sat = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
      n_vec++;
      if (conflict_err !== m_conf || redirect_cnt !== e_cnt || s_redirect_cnt !== e_sat) begin
        n_err++;
        $display("FAIL rand%0d_regs got conf=%b cnt=%0d sat=%0d want conf=%b cnt=%0d sat=%0d",
                 i, conflict_err, redirect_cnt, s_redirect_cnt, m_conf, e_cnt, e_sat);
      end
    end
    rst = 0; clear_inputs();
  endtask

  initial begin
    m_conf = 0; m_cnt = 0;
    rst = 1; fetch_ready = 0; clear_inputs();
    test_reset();
    test_idle();
    test_bra();
    test_jalr_vs_j();
    test_pend();
    test_stall();
    test_conflict_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
